// File: rtl/instr_fetch_if.sv
// Instruction memory bus between the fetch unit and instruction memory.
// The fetch unit drives the request and address. Memory returns the
// instruction word together with an acknowledge.
interface instr_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ack
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ack
  );
endinterface

// File: rtl/instr_fetch.sv
// InstrFetch: single-outstanding-request instruction fetch stage.
// The unit requests one word and holds it for decode until it is accepted.
// It then advances the PC by 4, which leaves one bubble cycle per instruction.
// A redirect (branch/jump) takes priority over a memory acknowledge and over
// a hand-off.
// Optional feature macro: IF_HALT_EN. When it is defined, the word
// 32'hFFFF_FFFF is handed off normally and then parks the unit in HALT.
// The unit leaves HALT only through a redirect or a reset.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  instr_fetch_if.master         imem,
  output logic [31:0]           inst_o,
  output logic [31:0]           inst_pc_o,
  output logic                  inst_valid_o,
  input  logic                  dec_ready_i,
  input  logic                  stall_i,
  input  logic                  redirect_valid_i,
  input  logic [31:0]           redirect_pc_i,
  output logic [5:0]            pc_dbg_o,
  output logic [15:0]           fetch_cnt_o,
  output logic                  halted_o
);

  localparam logic [31:0] ResetPcAligned = {RESET_PC[31:2], 2'b00};
  localparam logic [31:0] AlignMask      = 32'hFFFF_FFFC;
  localparam logic [15:0] CntMax         = 16'hFFFF;
`ifdef IF_HALT_EN
  localparam logic [31:0] HaltWord       = 32'hFFFF_FFFF;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
`ifdef IF_HALT_EN
    ,
    HALT = 2'd3
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        inst_valid_q, inst_valid_d;
  logic [15:0] fetch_cnt_q, fetch_cnt_d;
  logic        redirect_take;
  logic        handoff;

  // Registers all fetch state; a low rst at an edge wins over everything else
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      pc_q         <= ResetPcAligned;
      inst_q       <= 32'h0;
      inst_pc_q    <= 32'h0;
      inst_valid_q <= 1'b0;
      fetch_cnt_q  <= 16'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      fetch_cnt_q  <= fetch_cnt_d;
    end
  end

  // Next-state logic: a redirect first, then the acknowledge in REQ, then the hand-off in HOLD
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    fetch_cnt_d  = fetch_cnt_q;
    handoff      = 1'b0;

    redirect_take = redirect_valid_i && (state_q != IDLE);

    if (redirect_take) begin
      pc_d         = redirect_pc_i & AlignMask;
      inst_valid_d = 1'b0;
      state_d      = REQ;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = REQ;
        end
        REQ: begin
          if (imem.imem_ack) begin
            inst_d       = imem.imem_rdata;
            inst_pc_d    = pc_q;
            inst_valid_d = 1'b1;
            pc_d         = pc_q + 32'd4;
            state_d      = HOLD;
          end
        end
        HOLD: begin
          if (dec_ready_i && !stall_i) begin
            handoff      = 1'b1;
            inst_valid_d = 1'b0;
`ifdef IF_HALT_EN
            state_d      = (inst_q == HaltWord) ? HALT : REQ;
`else
            state_d      = REQ;
`endif
          end
        end
`ifdef IF_HALT_EN
        HALT: begin
          state_d = HALT;
        end
`endif
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    if (handoff && (fetch_cnt_q != CntMax)) begin
      fetch_cnt_d = fetch_cnt_q + 16'd1;
    end
  end

  // The request is masked while rst is low so that a reset in the middle of a request abandons it at once
  always_comb begin
    imem.imem_req  = rst && (state_q == REQ);
    imem.imem_addr = pc_q;
  end

  // Drives the decode-side and debug outputs from the registers
  always_comb begin
    inst_o       = inst_q;
    inst_pc_o    = inst_pc_q;
    inst_valid_o = inst_valid_q;
    pc_dbg_o     = pc_q[7:2];
    fetch_cnt_o  = fetch_cnt_q;
`ifdef IF_HALT_EN
    halted_o     = (state_q == HALT);
`else
    halted_o     = 1'b0;
`endif
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed-vector bench for instr_fetch.
// The bench covers the following behaviour:
//   - The reset state of the unit.
//   - Sequential fetch and hand-off to decode.
//   - Holding the instruction while decode is stalled.
//   - A redirect that arrives together with an acknowledge.
//   - A redirect during HOLD.
//   - Wrap of the PC at the top of the address space.
//   - Reset in the middle of HOLD and in the middle of a request.
//   - Handling of the 32'hFFFF_FFFF word, in either build.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        decReady;
  logic        stall;
  logic        redirValid;
  logic [31:0] redirPc;

  logic [31:0] inst0, instPc0, inst1, instPc1;
  logic        instValid0, instValid1, halted0, halted1;
  logic [5:0]  pcDbg0, pcDbg1;
  logic [15:0] fetchCnt0, fetchCnt1;

  int assertCount = 0;
  int failCount   = 0;

  instr_fetch_if busA();
  instr_fetch_if busB();

  instr_fetch dut0 (
    .clk              (clk),
    .rst              (rst),
    .imem             (busA),
    .inst_o           (inst0),
    .inst_pc_o        (instPc0),
    .inst_valid_o     (instValid0),
    .dec_ready_i      (decReady),
    .stall_i          (stall),
    .redirect_valid_i (redirValid),
    .redirect_pc_i    (redirPc),
    .pc_dbg_o         (pcDbg0),
    .fetch_cnt_o      (fetchCnt0),
    .halted_o         (halted0)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clk              (clk),
    .rst              (rst),
    .imem             (busB),
    .inst_o           (inst1),
    .inst_pc_o        (instPc1),
    .inst_valid_o     (instValid1),
    .dec_ready_i      (decReady),
    .stall_i          (stall),
    .redirect_valid_i (redirValid),
    .redirect_pc_i    (redirPc),
    .pc_dbg_o         (pcDbg1),
    .fetch_cnt_o      (fetchCnt1),
    .halted_o         (halted1)
  );

  // Free-running clock with a 10-unit period
  always #5 clk = ~clk;

  // Advances one rising edge, then moves off the edge so that outputs are sampled after they settle
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Compares one observed value with its expected value and counts the comparison
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Applies the directed vectors one after another and checks the results
  task automatic applyStimulus();
    busA.imem_ack = 1'b0; busA.imem_rdata = 32'h0;
    busB.imem_ack = 1'b0; busB.imem_rdata = 32'h0;
    decReady = 1'b1; stall = 1'b0; redirValid = 1'b0; redirPc = 32'h0;

    rst = 1'b0;
    stepCycle();
    stepCycle();
    checkOutput("rstValid", 32'(instValid0), 32'h0);
    checkOutput("rstCnt", 32'(fetchCnt0), 32'h0);
    checkOutput("rstReq", 32'(busA.imem_req), 32'h0);
    checkOutput("rstInst", inst0, 32'h0);
    checkOutput("rstHalted", 32'(halted0), 32'h0);

    rst = 1'b1;
    #1;
    checkOutput("idleNoReq", 32'(busA.imem_req), 32'h0);
    stepCycle();
    checkOutput("reqUp", 32'(busA.imem_req), 32'h1);
    checkOutput("dut1Addr", busB.imem_addr, 32'hFFFF_FFFC);
    checkOutput("dut1PcDbg", 32'(pcDbg1), 32'h3F);

    busA.imem_ack = 1'b1;
    busB.imem_ack = 1'b1;
    busB.imem_rdata = 32'h0BAD_0001;
    for (int i = 0; i < 4; i++) begin
      checkOutput("seqAddr", busA.imem_addr, 32'(4 * i));
      busA.imem_rdata = 32'h1000_0000 + 32'(i);
      stepCycle();
      if (i == 0) begin
        busB.imem_ack = 1'b0;
        checkOutput("dut1InstPc", instPc1, 32'hFFFF_FFFC);
        checkOutput("dut1Wrap", busB.imem_addr, 32'h0000_0000);
      end
      checkOutput("seqInst", inst0, 32'h1000_0000 + 32'(i));
      checkOutput("seqInstPc", instPc0, 32'(4 * i));
      checkOutput("seqValid", 32'(instValid0), 32'h1);
      checkOutput("holdNoReq", 32'(busA.imem_req), 32'h0);
      stepCycle();
      checkOutput("seqCnt", 32'(fetchCnt0), 32'(i + 1));
      checkOutput("seqValidDrop", 32'(instValid0), 32'h0);
    end
    checkOutput("cnt4", 32'(fetchCnt0), 32'd4);
    checkOutput("pcDbg4", 32'(pcDbg0), 32'h04);
    checkOutput("addr10", busA.imem_addr, 32'h10);

    stall = 1'b1;
    busA.imem_rdata = 32'hA5A5_0001;
    stepCycle();
    busA.imem_rdata = 32'hDEAD_BEEF;
    for (int k = 0; k < 5; k++) begin
      stepCycle();
      checkOutput("stallInst", inst0, 32'hA5A5_0001);
      checkOutput("stallValid", 32'(instValid0), 32'h1);
      checkOutput("stallCnt", 32'(fetchCnt0), 32'd4);
    end
    stall = 1'b0;
    stepCycle();
    checkOutput("stallRelCnt", 32'(fetchCnt0), 32'd5);
    checkOutput("stallRelValid", 32'(instValid0), 32'h0);
    checkOutput("stallRelAddr", busA.imem_addr, 32'h14);

    busA.imem_rdata = 32'h1234_5678;
    redirValid = 1'b1;
    redirPc = 32'h43;
    stepCycle();
    redirValid = 1'b0;
    busA.imem_ack = 1'b0;
    checkOutput("redirValid", 32'(instValid0), 32'h0);
    checkOutput("redirAddr", busA.imem_addr, 32'h40);
    checkOutput("redirReq", 32'(busA.imem_req), 32'h1);
    checkOutput("redirCnt", 32'(fetchCnt0), 32'd5);
    checkOutput("redirDrop", inst0, 32'hA5A5_0001);

    busA.imem_ack = 1'b1;
    busA.imem_rdata = 32'hFFFF_FFFF;
    stepCycle();
    busA.imem_ack = 1'b0;
    checkOutput("onesInst", inst0, 32'hFFFF_FFFF);
    checkOutput("onesInstPc", instPc0, 32'h40);
    stepCycle();
    checkOutput("onesCnt", 32'(fetchCnt0), 32'd6);
`ifdef IF_HALT_EN
    checkOutput("haltFlag", 32'(halted0), 32'h1);
    checkOutput("haltNoReq", 32'(busA.imem_req), 32'h0);
    busA.imem_ack = 1'b1;
    stepCycle();
    stepCycle();
    stepCycle();
    busA.imem_ack = 1'b0;
    checkOutput("haltStay", 32'(halted0), 32'h1);
    checkOutput("haltStayReq", 32'(busA.imem_req), 32'h0);
    checkOutput("haltPcFrozen", 32'(pcDbg0), 32'h11);
`else
    checkOutput("noHaltFlag", 32'(halted0), 32'h0);
    checkOutput("noHaltReq", 32'(busA.imem_req), 32'h1);
    checkOutput("noHaltAddr", busA.imem_addr, 32'h44);
`endif
    redirValid = 1'b1;
    redirPc = 32'h20;
    stepCycle();
    redirValid = 1'b0;
    checkOutput("exitAddr", busA.imem_addr, 32'h20);
    checkOutput("exitHalted", 32'(halted0), 32'h0);
    checkOutput("exitReq", 32'(busA.imem_req), 32'h1);

    decReady = 1'b0;
    busA.imem_ack = 1'b1;
    busA.imem_rdata = 32'h77;
    stepCycle();
    busA.imem_ack = 1'b0;
    stepCycle();
    checkOutput("notReadyValid", 32'(instValid0), 32'h1);
    checkOutput("notReadyInst", inst0, 32'h77);
    checkOutput("notReadyPc", instPc0, 32'h20);
    redirValid = 1'b1;
    redirPc = 32'h80;
    decReady = 1'b1;
    stepCycle();
    redirValid = 1'b0;
    checkOutput("holdRedirValid", 32'(instValid0), 32'h0);
    checkOutput("holdRedirCnt", 32'(fetchCnt0), 32'd6);
    checkOutput("holdRedirAddr", busA.imem_addr, 32'h80);

    decReady = 1'b0;
    busA.imem_ack = 1'b1;
    busA.imem_rdata = 32'h99;
    stepCycle();
    busA.imem_ack = 1'b0;
    checkOutput("preRstValid", 32'(instValid0), 32'h1);
    rst = 1'b0;
    stepCycle();
    checkOutput("midRstValid", 32'(instValid0), 32'h0);
    checkOutput("midRstCnt", 32'(fetchCnt0), 32'h0);
    checkOutput("midRstInst", inst0, 32'h0);
    checkOutput("midRstInstPc", instPc0, 32'h0);
    checkOutput("midRstPcDbg", 32'(pcDbg0), 32'h0);
    checkOutput("midRstReq", 32'(busA.imem_req), 32'h0);
    stepCycle();
    rst = 1'b1;
    stepCycle();
    checkOutput("reReq", 32'(busA.imem_req), 32'h1);
    checkOutput("reAddr", busA.imem_addr, 32'h0);
    rst = 1'b0;
    #1;
    checkOutput("rstMaskReq", 32'(busA.imem_req), 32'h0);
    stepCycle();
    rst = 1'b1;
    decReady = 1'b1;
  endtask

  // Runs the vectors and prints the summary line
  initial begin
    applyStimulus();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
